// File: rtl/perf_ctrl.sv
// Performance measurement controller: counts cycles and retired instructions
// between start and halt, then derives CPI with a serial restoring divider.
// Optional watchdog enabled by defining PERF_WATCHDOG_EN.
module perf_ctrl #(
  parameter int unsigned CYCLE_LIMIT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        isHalt,
  input  logic        W_v,
  input  logic [15:0] numIns,
  output logic        running,
  output logic        busy,
  output logic        done,
  output logic [31:0] cycles,
  output logic [31:0] instrs,
  output logic [31:0] cpi,
  output logic        cpiValid,
  output logic        timeout
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

`ifdef PERF_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [W-1:0] LIMIT   = W'(CYCLE_LIMIT);
  localparam logic [W-1:0] CYC_CAP = WD_EN ? LIMIT : {W{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic             div_load;
  logic [W-1:0]     quo;
  logic [W-1:0]     rem;
  logic [CNT_W-1:0] bit_cnt;

  logic             wd_hit;
  logic [W-1:0]     cycles_inc;
  logic [W:0]       rem_sh;
  logic             rem_ge;
  logic [W-1:0]     rem_nxt;
  logic [W-1:0]     quo_nxt;

  // Cycle counter clamps at the limit; with the watchdog on, a halt that
  // coincides with the limit still keeps cycles within CYCLE_LIMIT.
  always_comb begin
    wd_hit     = WD_EN && (cycles == LIMIT);
    cycles_inc = (cycles == CYC_CAP) ? cycles : cycles + W'(1);
  end

  // One restoring-division step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, quo[W-1]};
    rem_ge  = (rem_sh >= (W+1)'(instrs));
    rem_nxt = rem_ge ? W'(rem_sh - (W+1)'(instrs)) : W'(rem_sh);
    quo_nxt = {quo[W-2:0], rem_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (isHalt || wd_hit) state_nxt = DIV;
      DIV: begin
        if (div_load) begin
          if (instrs == '0) state_nxt = DONE;
        end else if (bit_cnt == CNT_W'(W-1)) begin
          state_nxt = DONE;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Status flags registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      running <= (state_nxt == RUN);
      busy    <= (state_nxt == RUN) || (state_nxt == DIV);
      done    <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles   <= '0;
      instrs   <= '0;
      cpi      <= '0;
      cpiValid <= 1'b0;
      timeout  <= 1'b0;
      div_load <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cycles   <= '0;
            instrs   <= '0;
            cpi      <= '0;
            cpiValid <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        RUN: begin
          div_load <= 1'b1;
          if (isHalt || !wd_hit) begin
            cycles <= cycles_inc;
            if (W_v) instrs <= instrs + W'(numIns);
          end else begin
            timeout <= 1'b1;
          end
        end
        DIV: begin
          if (div_load) begin
            div_load <= 1'b0;
            if (instrs == '0) begin
              cpi <= {W{1'b1}};
            end else begin
              quo     <= cycles;
              rem     <= '0;
              bit_cnt <= '0;
            end
          end else begin
            quo     <= quo_nxt;
            rem     <= rem_nxt;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(W-1)) begin
              cpi      <= quo_nxt;
              cpiValid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_ctrl.sv
// Self-checking bench for perf_ctrl: table of measurements plus hand-written
// reset, hold and ignored-start sequences, checked through a scoreboard queue.
module tb_perf_ctrl;

`ifdef PERF_WATCHDOG_EN
  localparam int unsigned LIM = 20;
`else
  localparam int unsigned LIM = 100000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        isHalt = 1'b0;
  logic        W_v = 1'b0;
  logic [15:0] numIns = '0;
  logic        running, busy, done, cpiValid, timeout;
  logic [31:0] cycles, instrs, cpi;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          n_run;
    int          period;
    logic [15:0] num_ins;
    bit          halt;
    int          poke;
    logic [31:0] e_cycles;
    logic [31:0] e_instrs;
    logic [31:0] e_cpi;
    bit          e_valid;
    bit          e_timeout;
    int          e_lat;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  perf_ctrl #(.CYCLE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .isHalt(isHalt), .W_v(W_v),
    .numIns(numIns), .running(running), .busy(busy), .done(done),
    .cycles(cycles), .instrs(instrs), .cpi(cpi), .cpiValid(cpiValid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start, then drive the RUN phase; halt (if any) lands on the last cycle.
  task automatic drive_run(input vec_t v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("run_running", 32'(running), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    for (int i = 0; i < v.n_run; i++) begin
      W_v    = (v.period != 0) && ((i % v.period) == 0);
      numIns = v.num_ins;
      isHalt = v.halt && (i == v.n_run - 1);
      start  = (v.poke == 1) && (i == v.n_run / 2);
      @(posedge clk); #1;
    end
    W_v = 1'b0; isHalt = 1'b0; start = 1'b0; numIns = '0;
  endtask

  task automatic wait_done(input bit poke_div);
    int   lat;
    vec_t e;
    lat = 0;
    for (int k = 1; k <= 80; k++) begin
      start = poke_div && (k == 5);
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (k == 1) begin
        chk("div_busy", 32'(busy), 32'd1);
        chk("div_running", 32'(running), 32'd0);
      end
    end
    start = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected a pending record");
    end else begin
      e = exp_q.pop_front();
      chk("latency", 32'(lat), 32'(e.e_lat));
      chk("cycles", cycles, e.e_cycles);
      chk("instrs", instrs, e.e_instrs);
      chk("cpi", cpi, e.e_cpi);
      chk("cpiValid", 32'(cpiValid), 32'(e.e_valid));
      chk("timeout", 32'(timeout), 32'(e.e_timeout));
    end
  endtask

  task automatic measure(input vec_t v);
    exp_q.push_back(v);
    drive_run(v);
    wait_done(v.poke == 2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cycles"}, cycles, 32'd0);
    chk({tag, "_instrs"}, instrs, 32'd0);
    chk({tag, "_cpi"}, cpi, 32'd0);
    chk({tag, "_cpiValid"}, 32'(cpiValid), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    vec_t last;

    //           n     per  numIns    halt poke cycles  instrs      cpi            valid tmo lat
    tbl.push_back('{100,  2, 16'd1,    1'b1, 0, 32'd100, 32'd50,     32'd2,         1'b1, 1'b0, 33});
    tbl.push_back('{7,    0, 16'd9,    1'b1, 0, 32'd7,   32'd0,      32'hFFFF_FFFF, 1'b0, 1'b0, 1});
    tbl.push_back('{3,    1, 16'hFFFF, 1'b1, 2, 32'd3,   32'd196605, 32'd0,         1'b1, 1'b0, 33});
    tbl.push_back('{1,    1, 16'd1,    1'b1, 0, 32'd1,   32'd1,      32'd1,         1'b1, 1'b0, 33});
    tbl.push_back('{37,   1, 16'd5,    1'b1, 1, 32'd37,  32'd185,    32'd0,         1'b1, 1'b0, 33});
    tbl.push_back('{250,  3, 16'd1,    1'b1, 1, 32'd250, 32'd84,     32'd2,         1'b1, 1'b0, 33});
    tbl.push_back('{1000, 1000, 16'd3, 1'b1, 0, 32'd1000, 32'd3,     32'd333,       1'b1, 1'b0, 33});
    tbl.push_back('{64,   8, 16'd2,    1'b1, 0, 32'd64,  32'd16,     32'd4,         1'b1, 1'b0, 33});
`ifdef PERF_WATCHDOG_EN
    tbl.push_back('{21,   1, 16'd3,    1'b0, 0, 32'd20,  32'd60,     32'd0,         1'b1, 1'b1, 33});
    tbl.push_back('{21,   1, 16'd3,    1'b1, 0, 32'd20,  32'd63,     32'd0,         1'b1, 1'b0, 33});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    last = tbl[0];
    foreach (tbl[i]) begin
      if (tbl[i].n_run > int'(LIM)) continue;
      measure(tbl[i]);
      last = tbl[i];
    end

    // DONE holds its results while start stays low.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_cycles", cycles, last.e_cycles);
    chk("hold_cpi", cpi, last.e_cpi);

    // Asynchronous reset in the middle of the division, then a clean rerun.
    drive_run(tbl[0]);
    repeat (11) @(posedge clk);
    #1;
    chk("mid_div_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    measure(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
